// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared FPro MMIO bus.
// One access per grant: cs held WAIT_CYCLES, single rd/wr strobe on the last cycle, then ack.

module mmio_bus_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_set,
  input  logic              rd_cap,
  input  logic [DATA_W-1:0] rd_in,
  output logic              ack,
  output logic [DATA_W-1:0] rd_data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack     <= 1'b0;
      rd_data <= '0;
    end else begin
      ack <= done_set;
      if (rd_cap) rd_data <= rd_in;
    end
  end
endmodule

module mmio_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              busy,
  output logic              grant_id
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]              req, wr_in, ack;
  logic [1:0][ADDR_W-1:0]  addr_in;
  logic [1:0][DATA_W-1:0]  wdata_in, rd_data;

  state_t     state;
  logic [3:0] cnt;
  logic       ptr, wr_lat, pick, last;

  assign req      = {m1_req, m0_req};
  assign wr_in    = {m1_wr, m0_wr};
  assign addr_in  = {m1_addr, m0_addr};
  assign wdata_in = {m1_wr_data, m0_wr_data};

  assign pick = (&req) ? ptr : req[1];
  // Strobe cycle: read data is sampled and the ack is armed at its closing edge.
  assign last = (state == ACCESS) && (cnt == 4'd0);

  generate
    for (genvar i = 0; i < 2; i++) begin : g_port
      mmio_bus_arbiter_port #(.DATA_W(DATA_W)) u_port (
        .clk      (clk),
        .rst_n    (reset),
        .done_set (last && (grant_id == 1'(i))),
        .rd_cap   (last && !wr_lat && (grant_id == 1'(i))),
        .rd_in    (mmio_rd_data),
        .ack      (ack[i]),
        .rd_data  (rd_data[i])
      );
    end
  endgenerate

  assign m0_ack     = ack[0];
  assign m1_ack     = ack[1];
  assign m0_rd_data = rd_data[0];
  assign m1_rd_data = rd_data[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      ptr          <= 1'b0;
      wr_lat       <= 1'b0;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          mmio_wr <= 1'b0;
          mmio_rd <= 1'b0;
          if (|req) begin
            state        <= ACCESS;
            grant_id     <= pick;
            wr_lat       <= wr_in[pick];
            mmio_addr    <= addr_in[pick];
            mmio_wr_data <= wdata_in[pick];
            cnt          <= CNT_INIT;
            mmio_cs      <= 1'b1;
            busy         <= 1'b1;
            // Strobes are registered, so a one-cycle access fires them straight from grant.
            if (CNT_INIT == 4'd0) begin
              mmio_wr <= wr_in[pick];
              mmio_rd <= !wr_in[pick];
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              mmio_wr <= wr_lat;
              mmio_rd <= !wr_lat;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          ptr          <= !grant_id;
          busy         <= 1'b0;
          mmio_addr    <= '0;
          mmio_wr_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed + randomized bench for mmio_bus_arbiter against a transaction-level model.

module tb_mmio_bus_arbiter;
  localparam int W  = 2;
  localparam int AW = 21;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req, m0_wr, m0_ack, m1_req, m1_wr, m1_ack;
  logic [AW-1:0] m0_addr, m1_addr, mmio_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
  logic [DW-1:0] mmio_wr_data, mmio_rd_data;
  logic          mmio_cs, mmio_wr, mmio_rd, busy, grant_id;

  mmio_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .busy(busy), .grant_id(grant_id)
  );

  // Slave: fixed content per address
  function automatic logic [DW-1:0] slot(input logic [AW-1:0] a);
    if (a == 21'h000060) return 32'h12345678;
    return ({11'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always_comb mmio_rd_data = slot(mmio_addr);

  int tests = 0;
  int fails = 0;

  // model state
  bit            mptr;
  logic [DW-1:0] mrd [2];
  bit            preq [2];
  bit            pwr [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    m0_req = preq[0]; m0_wr = pwr[0]; m0_addr = paddr[0]; m0_wr_data = pdata[0];
    m1_req = preq[1]; m1_wr = pwr[1]; m1_addr = paddr[1]; m1_wr_data = pdata[1];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {mmio_cs, mmio_wr, mmio_rd, m0_ack, m1_ack, busy}, 6'b0);
    chk({tag, "_bus"}, {mmio_addr, mmio_wr_data}, '0);
    chk({tag, "_rd0"}, m0_rd_data, mrd[0]);
    chk({tag, "_rd1"}, m1_rd_data, mrd[1]);
  endtask

  task automatic model_reset();
    mptr = 1'b0;
    mrd[0] = '0;
    mrd[1] = '0;
  endtask

  // Called during an IDLE cycle with requests driven; ends in the following IDLE cycle.
  task automatic do_txn(input bit keep, input bit meddle);
    int            w;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w  = (preq[0] && preq[1]) ? int'(mptr) : (preq[1] ? 1 : 0);
    wr = pwr[w]; a = paddr[w]; d = pdata[w];
    drive();
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      if (k <= W) begin
        chk("cs", mmio_cs, 1);
        chk("strobe", {mmio_wr, mmio_rd}, (k == W) ? {wr, !wr} : 2'b00);
        chk("addr", mmio_addr, a);
        chk("wdata", mmio_wr_data, d);
        chk("ack_early", {m1_ack, m0_ack}, 2'b00);
        if (k == 1 && meddle) begin
          preq[w] = 1'b0; paddr[w] = AW'($urandom); pdata[w] = $urandom; pwr[w] = 1'($urandom);
          drive();
        end
      end else begin
        chk("done_bus", {mmio_cs, mmio_wr, mmio_rd}, 3'b000);
        if (!wr) mrd[w] = slot(a);
        chk("ack", {m1_ack, m0_ack}, (w == 1) ? 2'b10 : 2'b01);
        mptr = (w == 0);
        if (!keep) begin
          preq[w] = 1'b0;
          drive();
        end
      end
      chk("busy", busy, 1);
      chk("grant", grant_id, w);
      chk("rd0", m0_rd_data, mrd[0]);
      chk("rd1", m1_rd_data, mrd[1]);
    end
    tick();
    chk("post_ctl", {mmio_cs, mmio_wr, mmio_rd, m0_ack, m1_ack, busy}, 6'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      preq[i] = 0; pwr[i] = 0; paddr[i] = '0; pdata[i] = '0;
    end
    model_reset();
    drive();

    // 1: reset, then quiet bus
    repeat (3) tick();
    chk_idle("in_reset");
    chk("grant_rst", grant_id, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
    end

    // 2: m0 write
    preq[0] = 1; pwr[0] = 1; paddr[0] = 21'h000041; pdata[0] = 32'hDEADBEEF;
    do_txn(0, 0);
    chk_idle("after_wr");

    // m0 read so m0_rd_data is nonzero before m1 reads
    preq[0] = 1; pwr[0] = 0; paddr[0] = 21'h000123;
    do_txn(0, 0);

    // 3: m1 read from slot 0x60
    preq[1] = 1; pwr[1] = 0; paddr[1] = 21'h000060; pdata[1] = 32'h0;
    do_txn(0, 0);
    chk("m1_rd_const", m1_rd_data, 32'h12345678);

    // 5: winner changes command and drops req after grant
    preq[0] = 1; pwr[0] = 1; paddr[0] = 21'h000777; pdata[0] = 32'hCAFEF00D;
    do_txn(0, 1);
    chk_idle("after_meddle");

    // 4: both requesting continuously from reset
    reset = 1'b0;
    model_reset();
    preq[0] = 1; pwr[0] = 0; paddr[0] = 21'h000010; pdata[0] = 32'h11111111;
    preq[1] = 1; pwr[1] = 1; paddr[1] = 21'h000020; pdata[1] = 32'h22222222;
    drive();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) do_txn(1, 0);
    preq[0] = 0; preq[1] = 0;
    drive();
    tick();
    chk_idle("after_rr");

    // 6: reset during ACCESS before strobe
    preq[0] = 1; pwr[0] = 1; paddr[0] = 21'h000033; pdata[0] = 32'h33333333;
    do_txn(0, 0);
    preq[0] = 1; pwr[0] = 1; paddr[0] = 21'h000044; pdata[0] = 32'h44444444;
    drive();
    tick();
    chk("pre_abort_cs", {mmio_cs, mmio_wr, mmio_rd}, 3'b100);
    #2 reset = 1'b0;
    model_reset();
    #1 chk_idle("abort");
    preq[0] = 1; pwr[0] = 0; paddr[0] = 21'h000055;
    preq[1] = 1; pwr[1] = 0; paddr[1] = 21'h000060;
    drive();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("abort_hold");
    end
    reset = 1'b1;
    do_txn(0, 0);
    do_txn(0, 0);
    chk_idle("after_abort");

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!preq[i] && $urandom_range(0, 1) == 1) begin
          preq[i]  = 1;
          pwr[i]   = 1'($urandom);
          paddr[i] = ($urandom_range(0, 3) == 0) ? 21'h000060 : AW'($urandom);
          pdata[i] = $urandom;
        end
      end
      if (!preq[0] && !preq[1]) begin
        drive();
        tick();
        chk_idle("rand_idle");
      end else begin
        do_txn(0, $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
